ram_preloader: RTL and testbench
================================

Name: ram_preloader

Overview:
- Upstream feeder for the RAM test port. Accepts a byte stream from a host link, packs bytes into 64-bit words little-endian, and writes each word into RAM at auto-incrementing addresses.
- Drives the top-level test_en/test_cs/test_we/test_oe/test_addr/test_data mux inputs, so the CPU is held off the RAM while a program image is loaded.

Parameters:
- ADDR_STEP, 8, address increment per written word (byte addressing).
- WR_CYCLES, 2, cycles ld_cs/ld_we are held high per write (range 1..15).
- CNT_W, 32, width of word_count and the internal written-word counter.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load; sampled only in IDLE
- base_addr  input  64  first write address; captured on accepted start
- word_count  input  CNT_W  number of 64-bit words to write; captured on accepted start
- in_valid  input  1  byte stream valid
- in_data  input  8  byte stream payload
- in_ready  output  1  byte accepted when in_valid && in_ready
- ld_en  output  1  to test_en; high from accepted start through the DONE cycle
- ld_cs  output  1  to test_cs
- ld_we  output  1  to test_we
- ld_oe  output  1  to test_oe; always 0
- ld_addr  output  64  to test_addr
- ld_data  output  64  to test_data
- busy  output  1  high in any state except IDLE
- done  output  1  one-cycle pulse when the final word's write completes

Behaviour:
- Reset (sync, priority over everything): state=IDLE. All outputs 0: ld_en, ld_cs, ld_we, ld_oe, in_ready, busy, done, ld_addr, ld_data. Byte index and word counter cleared. Reset mid-load aborts immediately; a partial word is discarded and no further write occurs.
- IDLE: in_ready=0. On start=1, capture base_addr into ld_addr and word_count into the counter. Go to DONE if word_count==0, else COLLECT.
- COLLECT: in_ready=1, ld_cs=ld_we=0. Each accepted byte k (k=0..7) goes to ld_data[8k+7:8k]. On acceptance of byte 7, go to WRITE next cycle. ld_data only changes in COLLECT.
- WRITE: in_ready=0. ld_cs=ld_we=1 for exactly WR_CYCLES cycles. ld_addr and ld_data are stable for the whole state. Then go to RECOVER.
- RECOVER: one cycle with ld_cs=ld_we=0; ld_addr and ld_data still stable (no address change while we is high). At the end of the cycle: ld_addr += ADDR_STEP (mod 2^64, wraps silently) and the counter decrements. Go to DONE if the counter reaches 0, else COLLECT.
- DONE: done=1 for one cycle, ld_en=1, busy=1. Next state is IDLE, where ld_en=0 and busy=0.
- Per-word latency: 8 accepted bytes, then 1+WR_CYCLES+1 cycles before the next byte is accepted.
- start while busy is ignored. in_valid outside COLLECT is not consumed.
- The block has no flow-control timeout. A stalled stream leaves it in COLLECT indefinitely; only reset recovers.
- ld_oe is constant 0. The block never reads RAM.

Optional Feature:
- Macro PRELOADER_CHECKSUM_EN.
- Defined:
  - adds output checksum[63:0]: XOR of every word written this load.
  - Cleared on accepted start and on reset.
  - Updated in the WRITE entry cycle; valid when done pulses; held until the next start.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then start, base_addr=0x100, word_count=2, bytes 0x01..0x10 -> writes 0x0807060504030201 at 0x100 and 0x100F0E0D0C0B0A09 at 0x108; done pulses once; ld_en falls the cycle after.
- WR_CYCLES=2, single word -> ld_cs/ld_we high exactly 2 cycles; addr/data unchanged from 1 cycle before ld_we rises to 1 cycle after it falls.
- word_count=0 -> no ld_cs assertion; done one cycle after start; in_ready never high.
- in_valid toggled randomly with 3 words -> in_ready low during WRITE/RECOVER; all 24 bytes captured in order; written data matches expected.
- Reset asserted after 5 bytes of word 1 (word 0 already written) -> next cycle all outputs 0, state IDLE; a new start at base 0x200 writes cleanly.
- Start pulsed mid-load, and base_addr=0xFFFFFFFFFFFFFFF8 with 2 words -> mid-load start ignored; second write goes to 0x0; with PRELOADER_CHECKSUM_EN, checksum equals the XOR of both words at done.

Source files
------------

// File: rtl/ram_preloader.sv
// ram_preloader
//
// Feeds the RAM test port from a host byte stream. Bytes are packed
// little-endian into 64-bit words, and each word is written at an
// auto-incrementing address while the CPU is held off the RAM.
//
// Optional feature: define PRELOADER_CHECKSUM_EN to add the `checksum`
// output. It is the XOR of every word written during the current load.
//
// Parameters:
//   ADDR_STEP  address increment per written word (byte addressing)
//   WR_CYCLES  cycles ld_cs/ld_we are held high per write (1..15)
//   CNT_W      width of word_count and the internal word counter
//
// Ports:
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   start       one-cycle load request, sampled only when idle
//   base_addr   first write address, captured on accepted start
//   word_count  number of 64-bit words to write, captured on accepted start
//   in_valid    byte stream valid
//   in_data     byte stream payload
//   in_ready    byte accepted when in_valid && in_ready
//   ld_en       test-port mux enable, high while a load is in progress
//   ld_cs       RAM chip select
//   ld_we       RAM write enable
//   ld_oe       RAM output enable, constant 0
//   ld_addr     RAM address
//   ld_data     RAM write data
//   busy        high in any state except idle
//   done        one-cycle pulse after the final word's write completes
//   checksum    (PRELOADER_CHECKSUM_EN only) XOR of written words

module ram_preloader #(
  parameter int unsigned ADDR_STEP = 8,
  parameter int unsigned WR_CYCLES = 2,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [63:0]      base_addr,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             ld_en,
  output logic             ld_cs,
  output logic             ld_we,
  output logic             ld_oe,
  output logic [63:0]      ld_addr,
  output logic [63:0]      ld_data,
  output logic             busy,
  output logic             done
`ifdef PRELOADER_CHECKSUM_EN
  ,
  output logic [63:0]      checksum
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StWrite,
    StRecover,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [63:0]      addr_q, addr_d;
  logic [63:0]      data_q, data_d;
  logic [2:0]       byte_idx_q, byte_idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       wr_cnt_q, wr_cnt_d;

  logic byte_acc;
  logic wr_last;

  assign byte_acc = (state_q == StCollect) && in_valid;
  assign wr_last  = (wr_cnt_q == 4'(WR_CYCLES - 1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = (word_count == '0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        if (byte_acc && (byte_idx_q == 3'd7)) begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (wr_last) begin
          state_d = StRecover;
        end
      end
      StRecover: begin
        // cnt_q still holds the pre-decrement value here
        state_d = (cnt_q == CNT_W'(1)) ? StDone : StCollect;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    byte_idx_d = byte_idx_q;
    cnt_d      = cnt_q;
    wr_cnt_d   = wr_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d     = base_addr;
          cnt_d      = word_count;
          byte_idx_d = '0;
        end
      end
      StCollect: begin
        if (in_valid) begin
          data_d[{byte_idx_q, 3'b000} +: 8] = in_data;
          // Wraps from 7 back to 0, ready for the next word
          byte_idx_d = byte_idx_q + 3'd1;
        end
      end
      StWrite: begin
        wr_cnt_d = wr_last ? 4'd0 : (wr_cnt_q + 4'd1);
      end
      StRecover: begin
        // Address moves only after we has dropped for a full cycle
        addr_d = addr_q + 64'(ADDR_STEP);
        cnt_d  = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      data_q     <= '0;
      byte_idx_q <= '0;
      cnt_q      <= '0;
      wr_cnt_q   <= '0;
    end else begin
      addr_q     <= addr_d;
      data_q     <= data_d;
      byte_idx_q <= byte_idx_d;
      cnt_q      <= cnt_d;
      wr_cnt_q   <= wr_cnt_d;
    end
  end

`ifdef PRELOADER_CHECKSUM_EN
  logic [63:0] checksum_q, checksum_d;

  always_comb begin
    checksum_d = checksum_q;
    if ((state_q == StIdle) && start) begin
      checksum_d = '0;
    end else if ((state_q == StWrite) && (wr_cnt_q == 4'd0)) begin
      checksum_d = checksum_q ^ data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      checksum_q <= '0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready = 1'b0;
    ld_cs    = 1'b0;
    ld_we    = 1'b0;
    ld_oe    = 1'b0;
    ld_en    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    ld_addr  = addr_q;
    ld_data  = data_q;
    unique case (state_q)
      StIdle: ;
      StCollect: begin
        in_ready = 1'b1;
        ld_en    = 1'b1;
        busy     = 1'b1;
      end
      StWrite: begin
        ld_cs = 1'b1;
        ld_we = 1'b1;
        ld_en = 1'b1;
        busy  = 1'b1;
      end
      StRecover: begin
        ld_en = 1'b1;
        busy  = 1'b1;
      end
      StDone: begin
        done  = 1'b1;
        ld_en = 1'b1;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ram_preloader.sv
// Self-checking bench for ram_preloader: table of load cases driven by a
// randomized byte feeder, plus a hand-written reset-abort sequence.
module tb_ram_preloader;

  localparam int WR = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] base_addr = '0;
  logic [31:0] word_count = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, ld_en, ld_cs, ld_we, ld_oe, busy, done;
  logic [63:0] ld_addr, ld_data;
`ifdef PRELOADER_CHECKSUM_EN
  logic [63:0] checksum;
`endif

  ram_preloader #(
    .ADDR_STEP(8),
    .WR_CYCLES(WR),
    .CNT_W    (32)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ld_en     (ld_en),
    .ld_cs     (ld_cs),
    .ld_we     (ld_we),
    .ld_oe     (ld_oe),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy),
    .done      (done)
`ifdef PRELOADER_CHECKSUM_EN
    ,
    .checksum  (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Byte feeder: presents the head of byte_q, pops it when accepted
  // ---------------------------------------------------------------------------
  logic [7:0] byte_q[$];
  int         valid_prob = 100;
  int         accepted_cnt = 0;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (byte_q.size() > 0 && $urandom_range(1, 100) <= valid_prob) begin
        in_valid = 1'b1;
        in_data  = byte_q[0];
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
      end
    end
  end

  always @(negedge clk) begin
    if (in_valid && in_ready && !reset && byte_q.size() > 0) begin
      void'(byte_q.pop_front());
      accepted_cnt <= accepted_cnt + 1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write monitor: records each write and checks the port protocol
  // ---------------------------------------------------------------------------
  logic [63:0] obs_addr[$];
  logic [63:0] obs_data[$];
  logic        we_prev = 1'b0;
  logic [63:0] prev_addr = '0;
  int          we_len = 0;
  int          done_cnt = 0;
  int          rdy_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (ld_en) chk("oe_low", {63'd0, ld_oe}, 64'd0);
      if (in_ready) rdy_cnt <= rdy_cnt + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (ld_we && !we_prev) begin
        chk("cs_with_we", {63'd0, ld_cs}, 64'd1);
        chk("addr_before_we", ld_addr, prev_addr);
        obs_addr.push_back(ld_addr);
        obs_data.push_back(ld_data);
        we_len <= 1;
      end else if (ld_we) begin
        chk("addr_during_we", ld_addr, obs_addr[$]);
        chk("data_during_we", ld_data, obs_data[$]);
        we_len <= we_len + 1;
      end else if (we_prev) begin
        chk("we_length", 64'(we_len), 64'(WR));
        chk("addr_after_we", ld_addr, obs_addr[$]);
        chk("data_after_we", ld_data, obs_data[$]);
      end
      if (ld_we) chk("ready_low_in_write", {63'd0, in_ready}, 64'd0);
    end
    we_prev   <= ld_we;
    prev_addr <= ld_addr;
  end

  // ---------------------------------------------------------------------------
  // One complete load against a reference model of the expected writes
  // ---------------------------------------------------------------------------
  task automatic run_load(input logic [63:0] base, input int n, input int prob,
                          input bit mid, input logic [63:0] exp_end,
                          input int exp_writes, input bit fixed);
    logic [7:0]  bytes[$];
    logic [63:0] exp_w[$];
    logic [63:0] word;
    logic [63:0] xs;
    logic [7:0]  b;
    int          lat, obs0, done0, rdy0;
    xs = '0;
    for (int i = 0; i < n * 8; i++) begin
      b = fixed ? 8'(i + 1) : 8'($urandom_range(0, 255));
      bytes.push_back(b);
      byte_q.push_back(b);
    end
    for (int w = 0; w < n; w++) begin
      word = '0;
      for (int k = 0; k < 8; k++) word = word | (64'(bytes[w * 8 + k]) << (8 * k));
      exp_w.push_back(word);
      xs = xs ^ word;
    end
    obs0  = obs_addr.size();
    done0 = done_cnt;
    rdy0  = rdy_cnt;
    valid_prob = prob;
    base_addr  = base;
    word_count = 32'(n);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 4000) begin
      if (mid && lat == 4) begin
        start      = 1'b1;
        base_addr  = 64'hDEAD_0000;
        word_count = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    if (!done) begin
      chk("done_timeout", 64'd0, 64'd1);
    end else begin
      if (prob == 100) chk("done_latency", 64'(lat), 64'(n * (9 + WR)));
      chk("ld_en_at_done", {63'd0, ld_en}, 64'd1);
      chk("busy_at_done", {63'd0, busy}, 64'd1);
      chk("addr_at_done", ld_addr, exp_end);
`ifdef PRELOADER_CHECKSUM_EN
      chk("checksum", checksum, xs);
`endif
      @(posedge clk);
      #1;
      chk("done_pulse_once", 64'(done_cnt - done0), 64'd1);
      chk("done_low_after", {63'd0, done}, 64'd0);
      chk("ld_en_low_after", {63'd0, ld_en}, 64'd0);
      chk("busy_low_after", {63'd0, busy}, 64'd0);
    end
    chk("write_count", 64'(obs_addr.size() - obs0), 64'(exp_writes));
    for (int w = 0; w < n && obs0 + w < obs_addr.size(); w++) begin
      chk("write_addr", obs_addr[obs0 + w], base + 64'(8 * w));
      chk("write_data", obs_data[obs0 + w], exp_w[w]);
    end
    if (n == 0) chk("ready_never_high", 64'(rdy_cnt - rdy0), 64'd0);
    if (fixed && n == 2 && obs_addr.size() - obs0 == 2) begin
      chk("word0_const", obs_data[obs0], 64'h0807060504030201);
      chk("word1_const", obs_data[obs0 + 1], 64'h100F0E0D0C0B0A09);
    end
  endtask

  typedef struct {
    logic [63:0] base;
    int          n;
    int          prob;
    bit          mid;
    logic [63:0] exp_end;
    int          exp_writes;
    bit          fixed;
  } load_vec_t;

  load_vec_t vecs[6];

  initial begin
    int acc0, obs0, guard;
    vecs[0] = '{64'h100, 2, 100, 1'b0, 64'h110, 2, 1'b1};
    vecs[1] = '{64'h1000, 1, 100, 1'b0, 64'h1008, 1, 1'b0};
    vecs[2] = '{64'h40, 0, 100, 1'b0, 64'h40, 0, 1'b0};
    vecs[3] = '{64'h2000, 3, 50, 1'b0, 64'h2018, 3, 1'b0};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFF8, 2, 70, 1'b1, 64'h8, 2, 1'b0};
    vecs[5] = '{64'h5_0000, 4, 30, 1'b1, 64'h5_0020, 4, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ld_en", {63'd0, ld_en}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_cs_we", {62'd0, ld_cs, ld_we}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_addr", ld_addr, 64'd0);
    chk("rst_data", ld_data, 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_load(vecs[i].base, vecs[i].n, vecs[i].prob, vecs[i].mid,
               vecs[i].exp_end, vecs[i].exp_writes, vecs[i].fixed);
      repeat (2) @(posedge clk);
      #1;
    end

    // Reset 5 bytes into word 1 of a 3-word load
    acc0 = accepted_cnt;
    obs0 = obs_addr.size();
    valid_prob = 100;
    for (int i = 0; i < 24; i++) byte_q.push_back(8'($urandom_range(0, 255)));
    base_addr  = 64'h3000;
    word_count = 32'd3;
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (accepted_cnt - acc0 < 13 && guard < 1000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("abort_reached", 64'(accepted_cnt - acc0), 64'd13);
    reset = 1'b1;
    byte_q.delete();
    @(posedge clk);
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_ld_en", {63'd0, ld_en}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd0);
    chk("abort_cs_we", {62'd0, ld_cs, ld_we}, 64'd0);
    chk("abort_addr", ld_addr, 64'd0);
    chk("abort_data", ld_data, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_writes", 64'(obs_addr.size() - obs0), 64'd1);
    if (obs_addr.size() > obs0) chk("abort_word0_addr", obs_addr[obs0], 64'h3000);
    run_load(64'h200, 1, 100, 1'b0, 64'h208, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
